cp0_exc_ctrl: RTL and testbench
===============================

# cp0_exc_ctrl

Exception/interrupt controller for the five-stage MIPS core; sits beside the M-stage pipeline register. It holds the SR, Cause, EPC and PRId coprocessor-0 registers and evaluates pending hardware interrupts and M-stage exception codes every cycle. From these it drives the `req` flush line into every stage register and the fetch redirect address. It also executes MTC0/MFC0/ERET presented at M.

## Interface
- `PRID`, default 32'h0000_4300: value returned for register 15.
- `HANDLER`, default 32'h0000_4180: exception entry PC.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low: one clock; reset is asynchronous and active-low.
- `pc_in`  in  32  PC of the instruction in M.
- `exc_in`  in  5  ExcCode raised by the M instruction; 0 = none.
- `slot_in`  in  1  M instruction is in a branch delay slot.
- `mtc0_in`  in  1  M instruction is MTC0.
- `eret_in`  in  1  M instruction is ERET.
- `cp0_addr`  in  5  CP0 register number (rd field).
- `wdata`  in  32  MTC0 write data (forwarded rt value).
- `hwint`  in  6  hardware interrupt lines, level-sensitive.
- `rdata`  out  32  combinational MFC0 read of `cp0_addr`.
- `req`  out  1  combinational flush request to all stage registers.
- `redirect`  out  1  combinational: fetch must load `redirect_pc` (`req | eret_in`).
- `redirect_pc`  out  32  `HANDLER` when `req`, else current EPC.
- `epc_out`  out  32  current EPC register.

## Operation
- Registers: SR(12) = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}, other bits read 0. Cause(13) = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}. EPC(14) is 32 bits with [1:0] always 0. PRId(15) = `PRID`. Any other address reads 0; writes to other addresses are ignored.
- IP register: Cause.IP <= `hwint` every cycle. It is read-only to MTC0.
- `int_pend` = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL.
- `exc_pend` = (`exc_in` != 0) & ~SR.EXL.
- `req` = `int_pend | exc_pend`. Interrupt takes priority; its ExcCode is 0.
- On an edge with `req`:
  - EXL <= 1.
  - ExcCode <= `int_pend` ? 0 : `exc_in`.
  - BD <= `slot_in`.
  - EPC <= `slot_in` ? `pc_in`-4 : `pc_in`, with bits [1:0] cleared. Subtraction is mod 2^32.
  - Any MTC0 or ERET in M that cycle is cancelled and has no effect.
- On an edge with `eret_in` and no `req`: EXL <= 0. `redirect_pc` = EPC; the ERET instruction itself does not cause a flush.
- On an edge with `mtc0_in` and no `req`:
  - addr 12 writes IM and EXL/IE from `wdata`.
  - addr 14 writes EPC <= {`wdata`[31:2],2'b0}.
  - addr 13 and addr 15 are ignored.
- MTC0 and ERET asserted together is illegal decode; ERET wins, MTC0 is dropped.
- `rdata` reflects register contents before the current edge's update; there is no write-through bypass.
- `exc_in` nonzero while EXL=1 is masked: no `req`, no state change, and the instruction proceeds.

## Timing
- Reset (`rst`=0, async): SR=0, Cause=0, EPC=0. The same values hold while `rst` is low.
  - Outputs during reset: `req`=0, `redirect`=`eret_in`, `redirect_pc`=EPC=0, `rdata` per address (15 → PRID).
  - Reset released mid-exception leaves EXL=0 and no pending state.
- `hwint` rising at edge n is captured into IP at edge n+1. `req` can assert in cycle n+1 and the flush takes effect at edge n+2.
- An exception at M asserts `req` in the same cycle. At that edge, all stage registers flush, StageM loads `HANDLER` into its PC, and EXL sets.
- Exactly one `req` cycle per event: EXL=1 blocks re-entry until ERET.
- The handler's ERET at M clears EXL at the edge. An interrupt still pending can assert `req` from the next cycle.
- MTC0 SR clearing EXL with an enabled pending IP: `req` asserts the cycle after the write edge.

## Test plan
- Reset: drive `rst`=0 mid-cycle → SR/Cause/EPC read 0 immediately; `rdata`(addr 15)=32'h0000_4300; `req`=0.
- Exception: `exc_in`=10, `pc_in`=32'h3010, `slot_in`=0 → `req`=1, `redirect_pc`=32'h4180 same cycle. After the edge: EPC=32'h3010, Cause[6:2]=10, SR.EXL=1.
- Delay slot: `exc_in`=4, `pc_in`=32'h3024, `slot_in`=1 → EPC=32'h3020, Cause[31]=1.
- Interrupt latency: SR=32'h0000_0401 (IM[10], IE), raise `hwint`[0] at edge n → `req`=1 in cycle n+1. After that edge: ExcCode=0, EXL=1. `hwint` held high produces no second `req` while EXL=1.
- ERET: EPC=32'h3040, EXL=1, `eret_in`=1 → `redirect`=1, `redirect_pc`=32'h3040. EXL=0 after the edge.
- Collision: `mtc0_in`=1 to EPC (`wdata`=32'h5003) in the same cycle as `exc_in`=12 at `pc_in`=32'h3000 → EPC=32'h3000, not 32'h5000. A standalone repeat of the MTC0 yields EPC=32'h5000.

Source files
------------

// File: rtl/cp0_exc_ctrl_if.sv
// M-stage CP0 bus: the instruction fields presented at M, plus the CP0 read,
// flush request and fetch redirect coming back.
interface cp0_exc_ctrl_if;
  logic [31:0] pc_in;
  logic [4:0]  exc_in;
  logic        slot_in;
  logic        mtc0_in;
  logic        eret_in;
  logic [4:0]  cp0_addr;
  logic [31:0] wdata;
  logic [5:0]  hwint;
  logic [31:0] rdata;
  logic        req;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] epc_out;

  modport master (
    output pc_in, exc_in, slot_in, mtc0_in, eret_in, cp0_addr, wdata, hwint,
    input  rdata, req, redirect, redirect_pc, epc_out
  );

  modport slave (
    input  pc_in, exc_in, slot_in, mtc0_in, eret_in, cp0_addr, wdata, hwint,
    output rdata, req, redirect, redirect_pc, epc_out
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller beside the M-stage register: holds SR,
// Cause, EPC, PRId and raises the pipeline flush and fetch redirect.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID    = 32'h0000_4300,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input logic           clk,
  input logic           rst,
  cp0_exc_ctrl_if.slave bus
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_pend;
  logic        exc_pend;
  logic        req;
  logic [31:0] exc_pc;

  // Flush is held off while rst is low so a stray exc_in cannot flush during reset.
  assign int_pend = (|(ip_q & im_q)) & ie_q & ~exl_q;
  assign exc_pend = (bus.exc_in != 5'd0) & ~exl_q;
  assign req      = rst & (int_pend | exc_pend);

  assign exc_pc = bus.slot_in ? (bus.pc_in - 32'd4) : bus.pc_in;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ip_d       = bus.hwint;
    if (req) begin
      exl_d      = 1'b1;
      exc_code_d = int_pend ? 5'd0 : bus.exc_in;
      bd_d       = bus.slot_in;
      epc_d      = exc_pc & 32'hFFFF_FFFC;
    end else if (bus.eret_in) begin
      // ERET beats a simultaneous MTC0 (illegal decode), so MTC0 is dropped here.
      exl_d = 1'b0;
    end else if (bus.mtc0_in) begin
      case (bus.cp0_addr)
        5'd12: begin
          im_d  = bus.wdata[15:10];
          exl_d = bus.wdata[1];
          ie_d  = bus.wdata[0];
        end
        5'd14:   epc_d = {bus.wdata[31:2], 2'b00};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // Reads show pre-edge contents; there is no bypass of a same-cycle MTC0.
  always_comb begin
    bus.rdata = 32'd0;
    case (bus.cp0_addr)
      5'd12:   bus.rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
      5'd13:   bus.rdata = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'b00};
      5'd14:   bus.rdata = epc_q;
      5'd15:   bus.rdata = PRID;
      default: bus.rdata = 32'd0;
    endcase
  end

  assign bus.req         = req;
  assign bus.redirect    = req | bus.eret_in;
  assign bus.redirect_pc = req ? HANDLER : epc_q;
  assign bus.epc_out     = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboarded bench for cp0_exc_ctrl: directed CP0 scenarios followed by
// randomized traffic, checked against a word-level register model.
module tb_cp0_exc_ctrl;
  localparam logic [31:0] PRID_C    = 32'h0000_4300;
  localparam logic [31:0] HANDLER_C = 32'h0000_4180;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic next_rst = 1'b0;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        req;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] epc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  // Architectural model: whole 32-bit register words.
  logic [31:0] m_sr = 32'd0;
  logic [31:0] m_cause = 32'd0;
  logic [31:0] m_epc = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_int();
    logic [5:0] ip;
    logic [5:0] im;
    ip = m_cause[15:10];
    im = m_sr[15:10];
    return (|(ip & im)) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return rst_n && (m_int() || (bus.exc_in != 5'd0 && !m_sr[1]));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_C;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_sr = 32'd0;
    m_cause = 32'd0;
    m_epc = 32'd0;
  endtask

  task automatic model_edge();
    logic r;
    logic i;
    if (!rst_n) begin
      model_reset();
    end else begin
      r = m_req();
      i = m_int();
      if (r) begin
        m_sr[1] = 1'b1;
        m_cause[6:2] = i ? 5'd0 : bus.exc_in;
        m_cause[31] = bus.slot_in;
        m_epc = (bus.slot_in ? bus.pc_in - 32'd4 : bus.pc_in) & ~32'd3;
      end else if (bus.eret_in) begin
        m_sr[1] = 1'b0;
      end else if (bus.mtc0_in) begin
        if (bus.cp0_addr == 5'd12) m_sr = bus.wdata & 32'h0000_FC03;
        else if (bus.cp0_addr == 5'd14) m_epc = bus.wdata & ~32'd3;
      end
      m_cause[15:10] = bus.hwint;
    end
  endtask

  task automatic cyc(input logic [4:0] addr, input logic mtc0, input logic [31:0] wd,
                     input logic eret, input logic [4:0] exc, input logic [31:0] pc,
                     input logic slot, input logic [5:0] hw);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    rst_n = next_rst;
    bus.cp0_addr = addr;
    bus.mtc0_in = mtc0;
    bus.wdata = wd;
    bus.eret_in = eret;
    bus.exc_in = exc;
    bus.pc_in = pc;
    bus.slot_in = slot;
    bus.hwint = hw;
    e.req = m_req();
    e.redirect = e.req | eret;
    e.rpc = e.req ? HANDLER_C : m_epc;
    e.epc = m_epc;
    e.rdata = m_read(addr);
    q.push_back(e);
  endtask

  task automatic idle(input logic [4:0] addr);
    cyc(addr, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 6'd0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a fresh response; compare it to the queued one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_req", {31'd0, bus.req}, {31'd0, e.req});
        chk("sb_redirect", {31'd0, bus.redirect}, {31'd0, e.redirect});
        chk("sb_redirect_pc", bus.redirect_pc, e.rpc);
        chk("sb_epc_out", bus.epc_out, e.epc);
        chk("sb_rdata", bus.rdata, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pc_in = 32'd0;
    bus.exc_in = 5'd0;
    bus.slot_in = 1'b0;
    bus.mtc0_in = 1'b0;
    bus.eret_in = 1'b0;
    bus.cp0_addr = 5'd15;
    bus.wdata = 32'd0;
    bus.hwint = 6'd0;

    // Asynchronous reset asserted mid-cycle.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_prid", bus.rdata, PRID_C);
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_epc", bus.epc_out, 32'd0);
    bus.cp0_addr = 5'd12;
    #1;
    chk("rst_sr", bus.rdata, 32'd0);
    bus.cp0_addr = 5'd13;
    #1;
    chk("rst_cause", bus.rdata, 32'd0);

    next_rst = 1'b0;
    idle(5'd15);
    next_rst = 1'b1;
    idle(5'd15);
    idle(5'd12);

    // Exception with no delay slot.
    cyc(5'd14, 1'b0, 32'd0, 1'b0, 5'd10, 32'h3010, 1'b0, 6'd0);
    settle();
    chk("exc_req", {31'd0, bus.req}, 32'd1);
    chk("exc_redirect_pc", bus.redirect_pc, HANDLER_C);
    idle(5'd14);
    settle();
    chk("exc_epc", bus.rdata, 32'h3010);
    idle(5'd13);
    settle();
    chk("exc_code", (bus.rdata >> 2) & 32'h1F, 32'd10);
    idle(5'd12);
    settle();
    chk("exc_exl", bus.rdata & 32'h2, 32'h2);

    // ERET back to an EPC rewritten inside the handler.
    cyc(5'd14, 1'b1, 32'h3040, 1'b0, 5'd0, 32'd0, 1'b0, 6'd0);
    cyc(5'd14, 1'b0, 32'd0, 1'b1, 5'd0, 32'd0, 1'b0, 6'd0);
    settle();
    chk("eret_redirect", {31'd0, bus.redirect}, 32'd1);
    chk("eret_redirect_pc", bus.redirect_pc, 32'h3040);
    chk("eret_no_flush", {31'd0, bus.req}, 32'd0);
    idle(5'd12);
    settle();
    chk("eret_exl_clear", bus.rdata & 32'h2, 32'd0);

    // Exception in a branch delay slot.
    cyc(5'd14, 1'b0, 32'd0, 1'b0, 5'd4, 32'h3024, 1'b1, 6'd0);
    idle(5'd14);
    settle();
    chk("slot_epc", bus.rdata, 32'h3020);
    idle(5'd13);
    settle();
    chk("slot_bd", bus.rdata >> 31, 32'd1);
    cyc(5'd12, 1'b0, 32'd0, 1'b1, 5'd0, 32'd0, 1'b0, 6'd0);

    // Interrupt latency and single-shot behaviour while EXL is set.
    cyc(5'd12, 1'b1, 32'h0000_0401, 1'b0, 5'd0, 32'h3200, 1'b0, 6'd0);
    cyc(5'd13, 1'b0, 32'd0, 1'b0, 5'd0, 32'h3204, 1'b0, 6'd1);
    settle();
    chk("int_not_yet", {31'd0, bus.req}, 32'd0);
    cyc(5'd13, 1'b0, 32'd0, 1'b0, 5'd0, 32'h3208, 1'b0, 6'd1);
    settle();
    chk("int_req", {31'd0, bus.req}, 32'd1);
    cyc(5'd13, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 6'd1);
    settle();
    chk("int_once", {31'd0, bus.req}, 32'd0);
    chk("int_code", (bus.rdata >> 2) & 32'h1F, 32'd0);
    cyc(5'd12, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 6'd1);
    settle();
    chk("int_held_no_req", {31'd0, bus.req}, 32'd0);
    chk("int_exl", bus.rdata & 32'h2, 32'h2);
    idle(5'd14);
    settle();
    chk("int_epc", bus.rdata, 32'h3208);
    cyc(5'd12, 1'b0, 32'd0, 1'b1, 5'd0, 32'd0, 1'b0, 6'd0);

    // MTC0 to EPC colliding with an exception is cancelled.
    cyc(5'd14, 1'b1, 32'h5003, 1'b0, 5'd12, 32'h3000, 1'b0, 6'd0);
    idle(5'd14);
    settle();
    chk("collide_epc", bus.rdata, 32'h3000);
    cyc(5'd14, 1'b0, 32'd0, 1'b1, 5'd0, 32'd0, 1'b0, 6'd0);
    cyc(5'd14, 1'b1, 32'h5003, 1'b0, 5'd0, 32'd0, 1'b0, 6'd0);
    idle(5'd14);
    settle();
    chk("mtc0_epc", bus.rdata, 32'h5000);

    // Reset arriving mid-exception clears EXL and suppresses the flush.
    cyc(5'd12, 1'b0, 32'd0, 1'b0, 5'd7, 32'h3100, 1'b0, 6'd0);
    settle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rstexc_req", {31'd0, bus.req}, 32'd0);
    chk("rstexc_sr", bus.rdata, 32'd0);
    next_rst = 1'b0;
    idle(5'd12);
    next_rst = 1'b1;
    idle(5'd12);
    idle(5'd13);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] a;
      logic [4:0] ex;
      logic [5:0] hw;
      case ($urandom_range(0, 4))
        0: a = 5'd12;
        1: a = 5'd13;
        2: a = 5'd14;
        3: a = 5'd15;
        default: a = 5'($urandom);
      endcase
      ex = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      hw = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      cyc(a, ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 7) == 0),
          ex, $urandom, 1'($urandom_range(0, 1)), hw);
    end
    idle(5'd15);
    idle(5'd15);
    settle();
    chk("queue_drained", q.size(), 32'd0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
